// File: rtl/sample_ingress_pkg.sv
// rtl/sample_ingress_pkg.sv - FSM state encodings and count width shared by sample_ingress
// Used by the top, whose ovf_count register is gated by SAMPLE_INGRESS_OVF_COUNT_EN.
package sample_ingress_pkg;

  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {
    INGRESS_IDLE      = 2'd0,
    INGRESS_WAIT_ACK  = 2'd1,
    INGRESS_WAIT_DONE = 2'd2
  } ingress_state_e;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sample_ingress_if.sv
// rtl/sample_ingress_if.sv - sample source strobe and pipeline tick/ready handshake
// slave is the ingress block; master is whatever drives samples and models the pipeline.
interface sample_ingress_if #(
  parameter int data_width = 16
);
  logic signed [data_width-1:0] src_sample;
  logic                         src_valid;
  logic                         pipe_ready;
  logic signed [data_width-1:0] out_sample;
  logic                         out_valid;

  modport slave (
    input  src_sample, src_valid, pipe_ready,
    output out_sample, out_valid
  );

  modport master (
    output src_sample, src_valid, pipe_ready,
    input  out_sample, out_valid
  );
endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO, power-of-two depth, drops push on full unless popped
// Pointers wrap naturally in their $clog2(fifo_depth) bits.
module sample_fifo #(
  parameter int data_width = 16,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [data_width-1:0]         din,
  output logic [data_width-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(fifo_depth):0]   fill
);
  localparam int AW = $clog2(fifo_depth);

  logic [data_width-1:0] mem_q [fifo_depth];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           fill_q, fill_d;
  logic                  do_push, do_pop;

  assign full  = (fill_q == (AW+1)'(fifo_depth));
  assign empty = (fill_q == '0);
  assign fill  = fill_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop frees the slot the incoming sample needs, so full+pop still accepts.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sample_ingress.sv
// rtl/sample_ingress.sv - buffers sample strobes and issues them to the pipeline via tick/ready
// SAMPLE_INGRESS_OVF_COUNT_EN adds the saturating dropped-sample counter; otherwise ovf_count is 0.
module sample_ingress
  import sample_ingress_pkg::*;
#(
  parameter int data_width     = 16,
  parameter int fifo_depth     = 4,
  parameter int timeout_cycles = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  sample_ingress_if.slave             io,
  output logic [$clog2(fifo_depth):0] fill,
  output logic                        overflow,
  output logic                        timeout_err,
  output logic [COUNT_W-1:0]          ovf_count
);
  localparam int WD_W = $clog2(timeout_cycles + 1);

  ingress_state_e               state_q, state_d;
  logic signed [data_width-1:0] out_sample_q, out_sample_d;
  logic                         out_valid_q, out_valid_d;
  logic [WD_W-1:0]              wdog_q, wdog_d;
  logic                         overflow_q, overflow_d;
  logic                         timeout_err_q, timeout_err_d;

  logic                         issue, drop;
  logic                         fifo_full, fifo_empty;
  logic [data_width-1:0]        fifo_dout;

  sample_fifo #(
    .data_width (data_width),
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (io.src_valid),
    .pop   (issue),
    .din   (io.src_sample),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  always_comb begin
    state_d       = state_q;
    out_sample_d  = out_sample_q;
    out_valid_d   = 1'b0;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    issue         = 1'b0;

    case (state_q)
      INGRESS_IDLE: begin
        if (!fifo_empty && io.pipe_ready) begin
          issue        = 1'b1;
          out_sample_d = fifo_dout;
          out_valid_d  = 1'b1;
          wdog_d       = '0;
          state_d      = INGRESS_WAIT_ACK;
        end
      end
      INGRESS_WAIT_ACK:  if (!io.pipe_ready) state_d = INGRESS_WAIT_DONE;
      INGRESS_WAIT_DONE: if (io.pipe_ready)  state_d = INGRESS_IDLE;
      default:           state_d = INGRESS_IDLE;
    endcase

    // Watchdog spans both wait states; expiry overrides any handshake progress.
    if (state_q != INGRESS_IDLE) begin
      wdog_d = wdog_q + 1'b1;
      if (wdog_d == WD_W'(timeout_cycles)) begin
        timeout_err_d = 1'b1;
        state_d       = INGRESS_IDLE;
      end
    end

    drop       = io.src_valid && fifo_full && !issue;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= INGRESS_IDLE;
      out_sample_q  <= '0;
      out_valid_q   <= 1'b0;
      wdog_q        <= '0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_sample_q  <= out_sample_d;
      out_valid_q   <= out_valid_d;
      wdog_q        <= wdog_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign io.out_sample = out_sample_q;
  assign io.out_valid  = out_valid_q;
  assign overflow      = overflow_q;
  assign timeout_err   = timeout_err_q;

`ifdef SAMPLE_INGRESS_OVF_COUNT_EN
  logic [COUNT_W-1:0] ovf_count_q, ovf_count_d;

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (drop) ovf_count_d = sat_inc(ovf_count_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_count_q <= '0;
    else        ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_sample_ingress.sv
// tb/tb_sample_ingress.sv - directed checks of sample_ingress: vector table plus handshake sequences
module tb_sample_ingress;
  import sample_ingress_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 4096;
  localparam int BUSY  = 5;
`ifdef SAMPLE_INGRESS_OVF_COUNT_EN
  localparam bit OVFC_EN = 1'b1;
`else
  localparam bit OVFC_EN = 1'b0;
`endif

  typedef struct {
    logic        vld;
    logic [15:0] smp;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_smp;
    logic [2:0]  e_fill;
    logic        e_ovf;
    logic [15:0] e_ovfc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sample_ingress_if #(.data_width(DW)) io ();

  logic [$clog2(DEPTH):0] fill;
  logic                   overflow;
  logic                   timeout_err;
  logic [15:0]            ovf_count;

  sample_ingress #(
    .data_width     (DW),
    .fifo_depth     (DEPTH),
    .timeout_cycles (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io          (io),
    .fill        (fill),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .ovf_count   (ovf_count)
  );

  logic man_ready = 1'b1;
  logic model_en = 1'b0;
  logic model_ready = 1'b1;
  logic seen = 1'b0;
  int   left = 0;
  assign io.pipe_ready = model_en ? model_ready : man_ready;

  // Pipeline model: ready stays high over the edge after the tick, then low for BUSY edges.
  always @(negedge clk) begin
    if (!model_en) begin
      model_ready = 1'b1; seen = 1'b0; left = 0;
    end else if (io.out_valid) begin
      seen = 1'b1;
    end else if (seen) begin
      seen = 1'b0; model_ready = 1'b0; left = BUSY;
    end else if (!model_ready) begin
      left = left - 1;
      if (left == 0) model_ready = 1'b1;
    end
  end

  int cyc = 0;
  int tick_cyc[$];
  logic [15:0] tick_smp[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (io.out_valid) begin
      tick_cyc.push_back(cyc);
      tick_smp.push_back(io.out_sample);
    end
  end

  int total = 0;
  int bad = 0;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] oc(input int n);
    return OVFC_EN ? 16'(n) : 16'd0;
  endfunction

  function automatic void add(input logic vld, input logic [15:0] smp, input logic rdy,
                              input logic ev, input logic [15:0] es, input logic [2:0] ef,
                              input logic eo, input logic [15:0] ec);
    vec_t v;
    v.vld = vld; v.smp = smp; v.rdy = rdy;
    v.e_valid = ev; v.e_smp = es; v.e_fill = ef; v.e_ovf = eo; v.e_ovfc = ec;
    vt.push_back(v);
  endfunction

  task automatic do_reset();
    model_en = 1'b0; man_ready = 1'b1;
    io.src_valid = 1'b0; io.src_sample = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic void deliver_rest(input logic [15:0] last, input logic [15:0] nxt,
                                       input logic [2:0] f_after);
    add(0, 0, 1, 0, last, f_after + 3'd1, 1, oc(2));
    add(0, 0, 0, 0, last, f_after + 3'd1, 1, oc(2));
    add(0, 0, 1, 0, last, f_after + 3'd1, 1, oc(2));
    add(0, 0, 1, 1, nxt,  f_after,        1, oc(2));
  endfunction

  initial begin
    int push_edge;
    int nt;

    // Single sample: tick one edge after push, pipeline busy for 10 cycles.
    add(1, 16'h1234, 1, 0, 16'h0000, 1, 0, 0);
    add(0, 0, 1, 1, 16'h1234, 0, 0, 0);
    add(0, 0, 1, 0, 16'h1234, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 16'h1234, 0, 0, 0);
    add(0, 0, 1, 0, 16'h1234, 0, 0, 0);
    add(0, 0, 1, 0, 16'h1234, 0, 0, 0);
    // Overflow: six pushes into depth 4 with the pipeline held off.
    add(1, 16'h0A01, 0, 0, 16'h1234, 1, 0, 0);
    add(1, 16'h0A02, 0, 0, 16'h1234, 2, 0, 0);
    add(1, 16'h0A03, 0, 0, 16'h1234, 3, 0, 0);
    add(1, 16'h0A04, 0, 0, 16'h1234, 4, 0, 0);
    add(1, 16'h0A05, 0, 0, 16'h1234, 4, 1, oc(1));
    add(1, 16'h0A06, 0, 0, 16'h1234, 4, 1, oc(2));
    // Full plus pop plus push on the same edge: fill stays 4, count unchanged.
    add(1, 16'h0B07, 1, 1, 16'h0A01, 4, 1, oc(2));
    deliver_rest(16'h0A01, 16'h0A02, 3);
    deliver_rest(16'h0A02, 16'h0A03, 2);
    deliver_rest(16'h0A03, 16'h0A04, 1);
    deliver_rest(16'h0A04, 16'h0B07, 0);
    add(0, 0, 1, 0, 16'h0B07, 0, 1, oc(2));
    add(0, 0, 0, 0, 16'h0B07, 0, 1, oc(2));
    add(0, 0, 1, 0, 16'h0B07, 0, 1, oc(2));

    do_reset();
    #1;
    check("rst_out_valid", 32'(io.out_valid), 0);
    check("rst_out_sample", 32'(io.out_sample), 0);
    check("rst_fill", 32'(fill), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_ovf_count", 32'(ovf_count), 0);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      io.src_valid = vt[i].vld; io.src_sample = vt[i].smp; man_ready = vt[i].rdy;
      @(posedge clk); #1;
      check($sformatf("row%0d_valid", i), 32'(io.out_valid), 32'(vt[i].e_valid));
      check($sformatf("row%0d_sample", i), 32'(io.out_sample), 32'(vt[i].e_smp));
      check($sformatf("row%0d_fill", i), 32'(fill), 32'(vt[i].e_fill));
      check($sformatf("row%0d_ovf", i), 32'(overflow), 32'(vt[i].e_ovf));
      check($sformatf("row%0d_ovfc", i), 32'(ovf_count), 32'(vt[i].e_ovfc));
    end
    @(negedge clk); io.src_valid = 1'b0;

    // Burst of four while the pipeline model is busy between ticks.
    do_reset();
    model_en = 1'b1;
    tick_cyc.delete(); tick_smp.delete();
    push_edge = cyc + 1;
    for (int i = 1; i <= 4; i++) begin
      io.src_valid = 1'b1; io.src_sample = 16'(i);
      @(negedge clk);
    end
    io.src_valid = 1'b0;
    for (int i = 0; i < 200 && tick_cyc.size() < 4; i++) @(negedge clk);
    check("burst_ticks", 32'(tick_cyc.size()), 4);
    if (tick_cyc.size() >= 4) begin
      check("burst_first_latency", 32'(tick_cyc[0]), 32'(push_edge + 1));
      for (int i = 0; i < 4; i++)
        check($sformatf("burst_smp%0d", i), 32'(tick_smp[i]), 32'(i + 1));
      for (int i = 1; i < 4; i++)
        check($sformatf("burst_gap%0d", i), 32'(tick_cyc[i] - tick_cyc[i-1]), BUSY + 3);
    end
    repeat (BUSY + 4) @(negedge clk);
    check("burst_overflow", 32'(overflow), 0);
    check("burst_fill", 32'(fill), 0);

    // Watchdog: ready never returns after the tick.
    do_reset();
    io.src_valid = 1'b1; io.src_sample = 16'h0BAD; man_ready = 1'b1;
    @(negedge clk); io.src_valid = 1'b0;
    @(posedge clk); #1;
    check("wd_tick", 32'(io.out_valid), 1);
    @(negedge clk); man_ready = 1'b0;
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("wd_before_expiry", 32'(timeout_err), 0);
    @(posedge clk); #1;
    check("wd_expired", 32'(timeout_err), 1);
    @(negedge clk); man_ready = 1'b1; io.src_valid = 1'b1; io.src_sample = 16'h0C0D;
    @(negedge clk); io.src_valid = 1'b0;
    @(posedge clk); #1;
    check("wd_idle_tick", 32'(io.out_valid), 1);
    check("wd_idle_sample", 32'(io.out_sample), 32'h0C0D);

    // Reset asserted mid-handshake while in WAIT_DONE with one sample queued.
    @(negedge clk); man_ready = 1'b0; io.src_valid = 1'b1; io.src_sample = 16'h0E0E;
    @(negedge clk); io.src_valid = 1'b0;
    check("mid_fill_before", 32'(fill), 1);
    @(negedge clk); reset = 1'b0;
    #1;
    check("mid_out_valid", 32'(io.out_valid), 0);
    check("mid_out_sample", 32'(io.out_sample), 0);
    check("mid_fill", 32'(fill), 0);
    check("mid_timeout", 32'(timeout_err), 0);
    check("mid_overflow", 32'(overflow), 0);
    @(negedge clk); reset = 1'b1; io.src_valid = 1'b1; io.src_sample = 16'h0777;
    @(negedge clk); io.src_valid = 1'b0;
    nt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (io.out_valid) nt++;
    end
    check("mid_no_tick_while_busy", 32'(nt), 0);
    @(negedge clk); man_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_tick_after_ready", 32'(io.out_valid), 1);
    check("mid_tick_sample", 32'(io.out_sample), 32'h0777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
